grid_color_pipe: RTL and testbench

Parametrised, pipelined pixel-colour generator for the battleship grid renderer. Selects one of `NUM_SRC` board-memory sources by output-enable priority and maps its cell code through a runtime-writable palette. Overlays a frame-rate blinking cursor and forces black during blanking. Sits between the board memories and the VGA RGB output register, replacing the fixed combinational colour mapping.

---
 rtl/grid_color_pipe.sv | 132 +++++++++++++
 tb/tb_grid_color_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/grid_color_pipe.sv
// Two-stage pixel colour pipeline: prioritised board-memory source select, writable palette,
// blinking cursor overlay and blanking to black.
module grid_color_pipe #(
  parameter int unsigned          NUM_SRC       = 2,
  parameter int unsigned          DATA_W        = 2,
  parameter int unsigned          COLOR_W       = 12,
  parameter int unsigned          BLINK_HALF    = 30,
  parameter logic [COLOR_W-1:0]   DEFAULT_COLOR = 12'h8cf,
  parameter logic [COLOR_W-1:0]   CURSOR_COLOR  = 12'h0c0,
  localparam int unsigned         SEL_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [NUM_SRC-1:0]          src_oe,
  input  logic                        pix_valid,
  input  logic                        cursor_on,
  input  logic                        frame_tick,
  input  logic                        pal_we,
  input  logic [SEL_W+DATA_W-1:0]     pal_addr,
  input  logic [COLOR_W-1:0]          pal_wdata,
  output logic [COLOR_W-1:0]          grid_color,
  output logic                        grid_valid
);

  localparam int unsigned CODES   = 1 << DATA_W;
  localparam int unsigned DEPTH   = NUM_SRC * CODES;
  localparam int unsigned BLINK_W = $clog2(BLINK_HALF) + 1;
  localparam logic [SEL_W:0] NUM_SRC_L = (SEL_W+1)'(NUM_SRC);

  function automatic logic [COLOR_W-1:0] pal_default(input int unsigned src, input int unsigned code);
    logic [COLOR_W-1:0] c;
    c = DEFAULT_COLOR;
    if (src == 0) begin
      if (code == 0 || code == 1)      c = COLOR_W'(12'h8cf);
      else if (code == 2 || code == 3) c = COLOR_W'(12'h777);
    end else if (src == 1) begin
      if (code == 0 || code == 2)      c = COLOR_W'(12'h8cf);
      else if (code == 1)              c = COLOR_W'(12'hfff);
      else if (code == 3)              c = COLOR_W'(12'hf00);
    end
    return c;
  endfunction

  logic [COLOR_W-1:0] pal [DEPTH];

  logic [SEL_W-1:0]  sel_c;
  logic [DATA_W-1:0] code_c;
  logic              any_c;

  logic [SEL_W-1:0]  s1_sel;
  logic [DATA_W-1:0] s1_code;
  logic              s1_any, s1_cursor, s1_valid;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_vis;

  logic [SEL_W-1:0] wr_sel;
  logic             wr_ok;

  assign wr_sel = pal_addr[SEL_W+DATA_W-1 -: SEL_W];
  assign wr_ok  = pal_we && ({1'b0, wr_sel} < NUM_SRC_L);

  // Scan upward and latch only the first enabled source, giving lowest index priority.
  always_comb begin
    sel_c  = '0;
    code_c = '0;
    any_c  = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (src_oe[i] && !any_c) begin
        sel_c  = SEL_W'(i);
        code_c = src_data[i*DATA_W +: DATA_W];
        any_c  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < NUM_SRC; s++)
        for (int unsigned c = 0; c < CODES; c++)
          pal[s*CODES + c] <= pal_default(s, c);
    end else if (wr_ok) begin
      pal[pal_addr] <= pal_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_sel    <= '0;
      s1_code   <= '0;
      s1_any    <= 1'b0;
      s1_cursor <= 1'b0;
      s1_valid  <= 1'b0;
    end else begin
      s1_sel    <= sel_c;
      s1_code   <= code_c;
      s1_any    <= any_c;
      s1_cursor <= cursor_on;
      s1_valid  <= pix_valid;
    end
  end

  // Palette read sees pre-edge contents, so a same-edge write is not yet visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      grid_color <= '0;
      grid_valid <= 1'b0;
    end else begin
      grid_valid <= s1_valid;
      if (!s1_valid)                   grid_color <= '0;
      else if (s1_cursor && blink_vis) grid_color <= CURSOR_COLOR;
      else if (!s1_any)                grid_color <= DEFAULT_COLOR;
      else                             grid_color <= pal[{s1_sel, s1_code}];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
        blink_cnt <= '0;
        blink_vis <= ~blink_vis;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_grid_color_pipe.sv
// Bench for grid_color_pipe: directed scenarios then random traffic, all checked against
// a cycle-level behavioural model (palette table, frame count, one-deep input history).
module tb_grid_color_pipe;

  localparam int NS = 3;
  localparam int DW = 2;
  localparam int CW = 12;
  localparam int BH = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]   src_oe;
  logic            pix_valid, cursor_on, frame_tick, pal_we;
  logic [3:0]      pal_addr;
  logic [CW-1:0]   pal_wdata;
  logic [CW-1:0]   grid_color;
  logic            grid_valid;

  grid_color_pipe #(
    .NUM_SRC(NS), .DATA_W(DW), .COLOR_W(CW), .BLINK_HALF(BH),
    .DEFAULT_COLOR(12'h8cf), .CURSOR_COLOR(12'h0c0)
  ) dut (
    .clk(clk), .reset(reset), .src_data(src_data), .src_oe(src_oe),
    .pix_valid(pix_valid), .cursor_on(cursor_on), .frame_tick(frame_tick),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .grid_color(grid_color), .grid_valid(grid_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [11:0] mpal [16];
  int          ticks;
  logic        p_valid, p_cursor, p_any;
  int          p_idx;
  logic [11:0] e_color;
  logic        e_valid;

  function automatic logic [11:0] dflt(input int s, input int c);
    logic [11:0] t0 [4];
    logic [11:0] t1 [4];
    t0 = '{12'h8cf, 12'h8cf, 12'h777, 12'h777};
    t1 = '{12'h8cf, 12'hfff, 12'h8cf, 12'hf00};
    if (s == 0) return t0[c];
    if (s == 1) return t1[c];
    return 12'h8cf;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 16; a++) mpal[a] = dflt(a / 4, a % 4);
    ticks = 0;
    p_valid = 0; p_cursor = 0; p_any = 0; p_idx = 0;
    e_color = '0; e_valid = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      e_valid = p_valid;
      if (!p_valid)                              e_color = 12'h000;
      else if (p_cursor && ((ticks / BH) % 2 == 0)) e_color = 12'h0c0;
      else if (!p_any)                           e_color = 12'h8cf;
      else                                       e_color = mpal[p_idx];
      if (pal_we && pal_addr[3:2] != 2'd3) mpal[pal_addr] = pal_wdata;
      if (frame_tick) ticks++;
      p_valid  = pix_valid;
      p_cursor = cursor_on;
      p_any    = |src_oe;
      p_idx    = 0;
      for (int s = NS - 1; s >= 0; s--)
        if (src_oe[s]) p_idx = s * 4 + int'(src_data[s*DW +: DW]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("model_color", {20'd0, grid_color}, {20'd0, e_color});
    check_eq("model_valid", {31'd0, grid_valid}, {31'd0, e_valid});
  endtask

  task automatic set_pix(input logic [2:0] oe, input logic [1:0] d2, input logic [1:0] d1, input logic [1:0] d0);
    src_oe   = oe;
    src_data = {d2, d1, d0};
  endtask

  initial begin
    reset = 1; src_data = '0; src_oe = '0; pix_valid = 0; cursor_on = 0;
    frame_tick = 0; pal_we = 0; pal_addr = '0; pal_wdata = '0;
    model_reset();

    // Reset defaults and latency
    cycle(); cycle();
    check_eq("rst_color", {20'd0, grid_color}, 32'h000);
    check_eq("rst_valid", {31'd0, grid_valid}, 32'd0);
    reset = 0; pix_valid = 1; set_pix(3'b001, 2'd0, 2'd0, 2'd2);
    cycle();
    check_eq("lat1_valid", {31'd0, grid_valid}, 32'd0);
    cycle();
    check_eq("lat2_color", {20'd0, grid_color}, 32'h777);
    check_eq("lat2_valid", {31'd0, grid_valid}, 32'd1);

    // Priority
    set_pix(3'b011, 2'd0, 2'd3, 2'd0); cycle(); cycle();
    check_eq("prio_src0", {20'd0, grid_color}, 32'h8cf);
    set_pix(3'b010, 2'd0, 2'd3, 2'd0); cycle(); cycle();
    check_eq("prio_src1", {20'd0, grid_color}, 32'hf00);
    set_pix(3'b000, 2'd0, 2'd3, 2'd0); cycle(); cycle();
    check_eq("prio_none", {20'd0, grid_color}, 32'h8cf);

    // Palette write timing
    set_pix(3'b010, 2'd0, 2'd1, 2'd0); cycle(); cycle();
    check_eq("pal_before", {20'd0, grid_color}, 32'hfff);
    pal_we = 1; pal_addr = 4'b0101; pal_wdata = 12'h0f0;
    cycle();
    check_eq("pal_same_edge", {20'd0, grid_color}, 32'hfff);
    pal_we = 0;
    cycle();
    check_eq("pal_after", {20'd0, grid_color}, 32'h0f0);

    // Out-of-range palette address ignored
    pal_we = 1; pal_addr = 4'b1101; pal_wdata = 12'h0ff;
    cycle(); pal_we = 0; cycle(); cycle();
    check_eq("pal_oor", {20'd0, grid_color}, 32'h0f0);

    // Blanking
    pix_valid = 0; cursor_on = 1; set_pix(3'b010, 2'd0, 2'd3, 2'd0);
    cycle(); cycle();
    check_eq("blank_color", {20'd0, grid_color}, 32'h000);
    check_eq("blank_valid", {31'd0, grid_valid}, 32'd0);

    // Blink with BLINK_HALF=2
    reset = 1; cycle(); reset = 0;
    pix_valid = 1; cursor_on = 1; set_pix(3'b001, 2'd0, 2'd0, 2'd2);
    cycle(); cycle();
    check_eq("blink_f0", {20'd0, grid_color}, 32'h0c0);
    frame_tick = 1; cycle(); cycle(); frame_tick = 0; cycle(); cycle();
    check_eq("blink_f2", {20'd0, grid_color}, 32'h777);
    frame_tick = 1; cycle(); cycle(); frame_tick = 0; cycle(); cycle();
    check_eq("blink_f4", {20'd0, grid_color}, 32'h0c0);

    // Reset mid-stream with concurrent palette write, blink hidden beforehand
    frame_tick = 1; cycle(); cycle(); frame_tick = 0;
    cursor_on = 0; cycle(); cycle();
    check_eq("mid_pre", {20'd0, grid_color}, 32'h777);
    reset = 1; pal_we = 1; pal_addr = 4'b0010; pal_wdata = 12'h123;
    cycle();
    check_eq("mid_rst_color", {20'd0, grid_color}, 32'h000);
    reset = 0; pal_we = 0;
    cycle();
    check_eq("mid_flush_color", {20'd0, grid_color}, 32'h000);
    check_eq("mid_flush_valid", {31'd0, grid_valid}, 32'd0);
    cycle();
    check_eq("mid_pal_kept", {20'd0, grid_color}, 32'h777);
    check_eq("mid_valid", {31'd0, grid_valid}, 32'd1);
    cursor_on = 1; cycle(); cycle();
    check_eq("mid_blink_vis", {20'd0, grid_color}, 32'h0c0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      reset      = ($urandom_range(0, 199) == 0);
      src_data   = NS*DW'($urandom);
      src_oe     = NS'($urandom);
      pix_valid  = ($urandom_range(0, 7) != 0);
      cursor_on  = ($urandom_range(0, 3) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      pal_we     = ($urandom_range(0, 5) == 0);
      pal_addr   = 4'($urandom);
      pal_wdata  = 12'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
